glb_pcfg_ctrl: RTL and testbench

//   GLB-side initiator of the parallel-config (pcfg) bus. Streams {addr,data} bitstream words

---
 rtl/glb_pcfg_pkg.sv | 17 +
 rtl/glb_pcfg_if.sv | 24 ++
 rtl/glb_pcfg_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_glb_pcfg_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pcfg_pkg.sv
// Shared types and default widths for the GLB parallel-config controller.
package glb_pcfg_pkg;

    localparam int unsigned PCFG_ADDR_W     = 32;
    localparam int unsigned PCFG_DATA_W     = 32;
    localparam int unsigned PCFG_BS_ADDR_W  = 16;
    localparam int unsigned PCFG_RD_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        RD_ISSUE,
        RD_WAIT
    } pcfg_state_e;

endpackage

// File: rtl/glb_pcfg_if.sv
// pcfg bus between a GLB tile (master) and the CGRA columns (slave).
interface glb_pcfg_if #(
    parameter int unsigned CGRA_CFG_ADDR_WIDTH = 32,
    parameter int unsigned CGRA_CFG_DATA_WIDTH = 32
);

    logic                           cgra_cfg_wr_en;
    logic                           cgra_cfg_rd_en;
    logic [CGRA_CFG_ADDR_WIDTH-1:0] cgra_cfg_addr;
    logic [CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_data;
    logic [CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_rd_data;
    logic                           cgra_cfg_rd_data_valid;

    modport master (
        output cgra_cfg_wr_en, cgra_cfg_rd_en, cgra_cfg_addr, cgra_cfg_data,
        input  cgra_cfg_rd_data, cgra_cfg_rd_data_valid
    );

    modport slave (
        input  cgra_cfg_wr_en, cgra_cfg_rd_en, cgra_cfg_addr, cgra_cfg_data,
        output cgra_cfg_rd_data, cgra_cfg_rd_data_valid
    );

endinterface

// File: rtl/glb_pcfg_ctrl.sv
// GLB pcfg initiator: streams bitstream words from SRAM onto the pcfg bus and services host read-backs.
// Optional cycle counter output cfg_cycles under `define PCFG_CTRL_PERF_CNT_EN.
module glb_pcfg_ctrl
    import glb_pcfg_pkg::*;
#(
    parameter int unsigned CGRA_CFG_ADDR_WIDTH = PCFG_ADDR_W,
    parameter int unsigned CGRA_CFG_DATA_WIDTH = PCFG_DATA_W,
    parameter int unsigned BS_ADDR_WIDTH       = PCFG_BS_ADDR_W,
    parameter int unsigned RD_TIMEOUT          = PCFG_RD_TIMEOUT
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [BS_ADDR_WIDTH-1:0]                     bs_base,
    input  logic [BS_ADDR_WIDTH-1:0]                     num_words,
    output logic                                         bs_rd_en,
    output logic [BS_ADDR_WIDTH-1:0]                     bs_rd_addr,
    input  logic [CGRA_CFG_ADDR_WIDTH+CGRA_CFG_DATA_WIDTH-1:0] bs_rd_data,
    input  logic                                         rd_req,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0]               rd_addr,
    output logic                                         rd_ack,
    output logic [CGRA_CFG_DATA_WIDTH-1:0]               rd_data,
    output logic                                         rd_err,
    glb_pcfg_if.master                                   pcfg,
    output logic                                         busy,
    output logic                                         done
`ifdef PCFG_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                                  cfg_cycles
`endif
);

    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    pcfg_state_e                    state_q, state_d;
    logic [BS_ADDR_WIDTH-1:0]       base_q, base_d;
    logic [BS_ADDR_WIDTH-1:0]       cnt_q, cnt_d;
    logic [BS_ADDR_WIDTH-1:0]       k_q, k_d;
    logic                           rd_pending_q, rd_pending_d;
    logic                           wr_en_q, wr_en_d;
    logic                           rd_en_q, rd_en_d;
    logic [CGRA_CFG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CGRA_CFG_DATA_WIDTH-1:0] data_q, data_d;
    logic                           rd_ack_q, rd_ack_d;
    logic [CGRA_CFG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                           rd_err_q, rd_err_d;
    logic                           done_q, done_d;
    logic [TW-1:0]                  wait_q, wait_d;
    logic                           stream_start;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        wait_d       = wait_q;
        rd_ack_d     = 1'b0;
        rd_data_d    = rd_data_q;
        rd_err_d     = rd_err_q;
        done_d       = 1'b0;
        rd_en_d      = 1'b0;
        stream_start = 1'b0;
        bs_rd_en     = 1'b0;
        bs_rd_addr   = base_q + k_q;
        // A word read last cycle is on bs_rd_data now; register it onto the bus.
        wr_en_d      = rd_pending_q;
        addr_d       = rd_pending_q ? bs_rd_data[CGRA_CFG_ADDR_WIDTH+CGRA_CFG_DATA_WIDTH-1 -: CGRA_CFG_ADDR_WIDTH] : '0;
        data_d       = rd_pending_q ? bs_rd_data[CGRA_CFG_DATA_WIDTH-1:0] : '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    stream_start = 1'b1;
                    if (num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read issues in the start cycle so N words finish in N+2 cycles.
                        bs_rd_en   = 1'b1;
                        bs_rd_addr = bs_base;
                        base_d     = bs_base;
                        cnt_d      = num_words;
                        k_d        = BS_ADDR_WIDTH'(1);
                        state_d    = (num_words == BS_ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                    end
                end else if (rd_req && !rd_ack_q) begin
                    // rd_req is still high in the ack cycle; do not re-issue it.
                    state_d = RD_ISSUE;
                    rd_en_d = 1'b1;
                    addr_d  = rd_addr;
                    data_d  = '0;
                end
            end
            STREAM: begin
                bs_rd_en = 1'b1;
                k_d      = k_q + BS_ADDR_WIDTH'(1);
                if (k_q == cnt_q - BS_ADDR_WIDTH'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!rd_pending_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                wait_d  = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (pcfg.cgra_cfg_rd_data_valid) begin
                    rd_ack_d  = 1'b1;
                    rd_data_d = pcfg.cgra_cfg_rd_data;
                    rd_err_d  = 1'b0;
                    state_d   = IDLE;
                end else if (wait_q == TW'(RD_TIMEOUT - 1)) begin
                    rd_ack_d  = 1'b1;
                    rd_data_d = '0;
                    rd_err_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        rd_pending_d = bs_rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            rd_pending_q <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rd_ack_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_err_q     <= 1'b0;
            done_q       <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            rd_pending_q <= rd_pending_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rd_ack_q     <= rd_ack_d;
            rd_data_q    <= rd_data_d;
            rd_err_q     <= rd_err_d;
            done_q       <= done_d;
            wait_q       <= wait_d;
        end
    end

`ifdef PCFG_CTRL_PERF_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (stream_start) begin
            cycles_d = '0;
        end else if ((state_q == STREAM || state_q == DRAIN) && cycles_q != '1) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign cfg_cycles = cycles_q;
`endif

    assign pcfg.cgra_cfg_wr_en = wr_en_q;
    assign pcfg.cgra_cfg_rd_en = rd_en_q;
    assign pcfg.cgra_cfg_addr  = addr_q;
    assign pcfg.cgra_cfg_data  = data_q;
    assign rd_ack              = rd_ack_q;
    assign rd_data             = rd_data_q;
    assign rd_err              = rd_err_q;
    assign done                = done_q;
    assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_glb_pcfg_ctrl.sv
// Randomized self-checking bench for glb_pcfg_ctrl against a cycle-timeline reference model.
module tb_glb_pcfg_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 16;
    localparam int RD_TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BW-1:0] bs_base;
    logic [BW-1:0] num_words;
    logic          bs_rd_en;
    logic [BW-1:0] bs_rd_addr;
    logic [AW+DW-1:0] bs_rd_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          busy;
    logic          done;
`ifdef PCFG_CTRL_PERF_CNT_EN
    logic [31:0]   cfg_cycles;
    logic [31:0]   exp_cycles;
`endif

    int checks = 0;
    int failures = 0;
    int cur_t = 0;
    logic [31:0] seed_a, seed_d;

    glb_pcfg_if #(.CGRA_CFG_ADDR_WIDTH(AW), .CGRA_CFG_DATA_WIDTH(DW)) pcfg_bus ();

    glb_pcfg_ctrl #(
        .CGRA_CFG_ADDR_WIDTH(AW),
        .CGRA_CFG_DATA_WIDTH(DW),
        .BS_ADDR_WIDTH(BW),
        .RD_TIMEOUT(RD_TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bs_base(bs_base),
        .num_words(num_words),
        .bs_rd_en(bs_rd_en),
        .bs_rd_addr(bs_rd_addr),
        .bs_rd_data(bs_rd_data),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_ack(rd_ack),
        .rd_data(rd_data),
        .rd_err(rd_err),
        .pcfg(pcfg_bus.master),
        .busy(busy),
        .done(done)
`ifdef PCFG_CTRL_PERF_CNT_EN
        ,
        .cfg_cycles(cfg_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Bitstream SRAM contents are a per-run scrambled function of the address.
    function automatic logic [AW+DW-1:0] word_of(input logic [BW-1:0] a);
        return {seed_a ^ {a, ~a}, seed_d + {16'h0, a} * 32'd40503};
    endfunction

    always @(posedge clk) begin
        if (bs_rd_en) bs_rd_data <= word_of(bs_rd_addr);
        else          bs_rd_data <= {$urandom, $urandom};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=0x%0h exp=0x%0h", tag, cur_t, got, exp);
        end
    endtask

    task automatic drive_idle();
        start     = 1'b0;
        bs_base   = '0;
        num_words = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        pcfg_bus.cgra_cfg_rd_data_valid = 1'b0;
        pcfg_bus.cgra_cfg_rd_data       = '0;
    endtask

    // One transaction: optional stream (base, n) and/or optional host read.
    // lat: cycles from cgra_cfg_rd_en to the response valid; -1 means no response.
    task automatic do_txn(input bit ds, input logic [BW-1:0] base, input int n,
                          input bit dr, input logic [AW-1:0] raddr, input int lat,
                          input logic [DW-1:0] rdat);
        int s, vt, ack_t, tend, done_t;
        bit sb, rb, exp_bs, exp_wr, exp_rd;
        logic [BW-1:0] ea;
        logic [AW+DW-1:0] ew;
        s      = ds ? ((n > 0) ? n + 2 : 1) : 0;
        done_t = (n > 0) ? n + 2 : 1;
        vt     = (lat >= 0) ? s + 1 + lat : -100;
        ack_t  = (lat >= 1 && lat <= RD_TO) ? s + 2 + lat : s + 2 + RD_TO;
        tend   = ds ? done_t + 1 : 0;
        if (dr && ack_t + 1 > tend) tend = ack_t + 1;
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            cur_t = t;
            sb = ds && n > 0 && t >= 1 && t <= n + 1;
            rb = dr && t >= s + 1 && t <= ack_t - 1;
            if (ds && t == 0) begin
                start     = 1'b1;
                bs_base   = base;
                num_words = BW'(n);
            end else begin
                start     = (sb || rb) ? 1'($urandom) : 1'b0;
                bs_base   = BW'($urandom);
                num_words = BW'($urandom);
            end
            rd_req  = dr && t <= ack_t;
            rd_addr = raddr;
            if (dr && t == vt) begin
                pcfg_bus.cgra_cfg_rd_data_valid = 1'b1;
                pcfg_bus.cgra_cfg_rd_data       = rdat;
            end else begin
                pcfg_bus.cgra_cfg_rd_data_valid =
                    (!dr || t <= s + 1 || t >= ack_t) && ($urandom_range(0, 3) == 0);
                pcfg_bus.cgra_cfg_rd_data = DW'($urandom);
            end
            #2;
            exp_bs = ds && t < n;
            exp_wr = ds && t >= 2 && t < n + 2;
            exp_rd = dr && t == s + 1;
            check("bs_rd_en", 64'(bs_rd_en), 64'(exp_bs));
            if (exp_bs) begin
                ea = base + BW'(t);
                check("bs_rd_addr", 64'(bs_rd_addr), 64'(ea));
            end
            check("wr_en", 64'(pcfg_bus.cgra_cfg_wr_en), 64'(exp_wr));
            if (exp_wr) begin
                ew = word_of(base + BW'(t - 2));
                check("wr_addr", 64'(pcfg_bus.cgra_cfg_addr), 64'(ew[AW+DW-1:DW]));
                check("wr_data", 64'(pcfg_bus.cgra_cfg_data), 64'(ew[DW-1:0]));
            end
            check("rd_en", 64'(pcfg_bus.cgra_cfg_rd_en), 64'(exp_rd));
            if (exp_rd) begin
                check("rd_cfg_addr", 64'(pcfg_bus.cgra_cfg_addr), 64'(raddr));
                check("rd_cfg_data", 64'(pcfg_bus.cgra_cfg_data), 64'(0));
            end
            check("done", 64'(done), 64'(ds && t == done_t));
            check("busy", 64'(busy), 64'(sb || rb));
            check("rd_ack", 64'(rd_ack), 64'(dr && t == ack_t));
            if (dr && t == ack_t) begin
                if (lat >= 1 && lat <= RD_TO) begin
                    check("rd_data", 64'(rd_data), 64'(rdat));
                    check("rd_err", 64'(rd_err), 64'(0));
                end else begin
                    check("rd_data_to", 64'(rd_data), 64'(0));
                    check("rd_err_to", 64'(rd_err), 64'(1));
                end
            end
        end
        @(negedge clk);
        drive_idle();
`ifdef PCFG_CTRL_PERF_CNT_EN
        if (ds) exp_cycles = (n > 0) ? 32'(n + 1) : 32'd0;
        #2;
        check("cfg_cycles", 64'(cfg_cycles), 64'(exp_cycles));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 64'(pcfg_bus.cgra_cfg_wr_en), 64'(0));
        check({tag, "_rd_en"}, 64'(pcfg_bus.cgra_cfg_rd_en), 64'(0));
        check({tag, "_addr"},  64'(pcfg_bus.cgra_cfg_addr),  64'(0));
        check({tag, "_data"},  64'(pcfg_bus.cgra_cfg_data),  64'(0));
        check({tag, "_bs_rd"}, 64'(bs_rd_en), 64'(0));
        check({tag, "_ack"},   64'(rd_ack),   64'(0));
        check({tag, "_rdata"}, 64'(rd_data),  64'(0));
        check({tag, "_err"},   64'(rd_err),   64'(0));
        check({tag, "_busy"},  64'(busy),     64'(0));
        check({tag, "_done"},  64'(done),     64'(0));
`ifdef PCFG_CTRL_PERF_CNT_EN
        check({tag, "_cycles"}, 64'(cfg_cycles), 64'(0));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d", cur_t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ds, dr;
        int n, lat;
        logic [BW-1:0] base;
        seed_a = $urandom;
        seed_d = $urandom;
`ifdef PCFG_CTRL_PERF_CNT_EN
        exp_cycles = '0;
`endif
        drive_idle();
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed scenarios.
        do_txn(1'b1, 16'h0010, 3, 1'b0, '0, -1, '0);
        do_txn(1'b1, 16'h0020, 0, 1'b0, '0, -1, '0);
        do_txn(1'b0, '0, 0, 1'b1, 32'h0000_0305, 4, 32'h0000_CAFE);
        do_txn(1'b0, '0, 0, 1'b1, 32'h0000_0412, -1, '0);
        do_txn(1'b1, 16'h0100, 2, 1'b1, 32'h0000_0201, 3, 32'h1234_5678);
        do_txn(1'b1, 16'hFFFE, 4, 1'b0, '0, -1, '0);
        do_txn(1'b1, 16'h0040, 1, 1'b0, '0, -1, '0);
        do_txn(1'b0, '0, 0, 1'b1, 32'h0000_0101, 15, 32'hBEEF_0001);
        do_txn(1'b0, '0, 0, 1'b1, 32'h0000_0102, 0, 32'hBEEF_0002);
        do_txn(1'b0, '0, 0, 1'b1, 32'h0000_0103, 16, 32'hBEEF_0003);

        // Reset mid-stream, then a clean restart.
        @(negedge clk);
        start = 1'b1; bs_base = 16'h0200; num_words = 16'd10;
        @(negedge clk);
        drive_idle();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        cur_t = 5;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef PCFG_CTRL_PERF_CNT_EN
        exp_cycles = '0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            cur_t = i;
            check("postrst_done", 64'(done), 64'(0));
            check("postrst_wr", 64'(pcfg_bus.cgra_cfg_wr_en), 64'(0));
            check("postrst_busy", 64'(busy), 64'(0));
        end
        do_txn(1'b1, 16'h0300, 5, 1'b0, '0, -1, '0);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            ds   = 1'($urandom);
            dr   = ds ? 1'($urandom) : 1'b1;
            base = ($urandom_range(0, 3) == 0) ? BW'(16'hFFF8 + $urandom_range(0, 7)) : BW'($urandom);
            n    = $urandom_range(0, 12);
            lat  = int'($urandom_range(0, 18)) - 1;
            do_txn(ds, base, n, dr, AW'($urandom), lat, DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
